// File: rtl/soc_mem_responder_pkg.sv
// Shared types and constants for the SoC memory responder: bus widths,
// byte-lane count, FSM state encoding and the address-window helper.
package soc_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // True when addr falls inside [base, base + 4*depth).
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input int unsigned       depth);
    logic [ADDR_W-1:0] offset;
    offset = addr - base;
    return (addr >= base) && ((offset >> 2) < depth);
  endfunction

endpackage

// File: rtl/soc_mem_responder_if.sv
// SoC memory bus: a single request/response handshake with one outstanding
// transaction at a time.
interface SoC_MemBus;
  import soc_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic [LANES-1:0]  byte_en;
  logic              req;
  logic [DATA_W-1:0] read_data;
  logic              valid;

  modport Master (
    output addr, write_data, write_en, byte_en, req,
    input  read_data, valid
  );

  modport Slave (
    input  addr, write_data, write_en, byte_en, req,
    output read_data, valid
  );

endinterface

// File: rtl/soc_mem_responder_spram.sv
// Single-port RAM, DEPTH_WORDS x 32, synchronous read, per-byte write enable.
// Read data reflects the word before any write on the same edge.
module soc_spram
  import soc_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [LANES-1:0]               be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // NOTE: storage arrays get no reset branch; contents must survive rst and a
  // reset would also stop the array mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int n = 0; n < LANES; n++) begin
        if (we && be[n]) mem[idx][8*n +: 8] <= wdata[8*n +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/soc_mem_responder.sv
// Memory responder: accepts one request in IDLE, optionally waits
// WAIT_CYCLES, then performs the RAM access and pulses valid for one cycle.
module soc_mem_responder
  import soc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int                DEPTH_WORDS  = 1024,
  parameter int                WAIT_CYCLES  = 0
) (
  input logic       clk,
  input logic       res,
  SoC_MemBus.Slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;
  logic [LANES-1:0]  be_q;
  logic              accept;
  logic              start_access;

  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_we;
  logic [LANES-1:0]  acc_be;
  logic              acc_in_range;
  logic [ADDR_W-1:0] acc_offset;
  logic [DATA_W-1:0] ram_rdata;

  assign accept = (state_q == IDLE) && bus.req;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (WAIT_CYCLES == 0) begin
            state_d      = RESP;
            start_access = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          start_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      be_q   <= '0;
    end else if (accept) begin
      addr_q <= bus.addr;
      data_q <= bus.write_data;
      we_q   <= bus.write_en;
      be_q   <= bus.byte_en;
    end
  end

  // With no wait states the access happens on the accepting edge, so the
  // request is taken straight off the bus (the same values being latched).
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr = bus.addr;
      acc_data = bus.write_data;
      acc_we   = bus.write_en;
      acc_be   = bus.byte_en;
    end else begin
      acc_addr = addr_q;
      acc_data = data_q;
      acc_we   = we_q;
      acc_be   = be_q;
    end
  end

  assign acc_in_range = in_window(acc_addr, BASE_ADDRESS, DEPTH_WORDS);
  assign acc_offset   = acc_addr - BASE_ADDRESS;

  soc_spram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (start_access && res),
    .we    (acc_we && acc_in_range),
    .be    (acc_be),
    .idx   (IDX_W'(acc_offset >> 2)),
    .wdata (acc_data),
    .rdata (ram_rdata)
  );

  assign bus.valid     = (state_q == RESP);
  assign bus.read_data = ((state_q == RESP) && !we_q &&
                          in_window(addr_q, BASE_ADDRESS, DEPTH_WORDS))
                         ? ram_rdata : '0;

endmodule

// File: tb/tb_soc_mem_responder.sv
// Self-checking bench: three responder configurations driven from shared bus
// inputs, checked against a word-level memory model.
module tb_soc_mem_responder;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0000;
  localparam logic [31:0] BASE2 = 32'h0000_1000;
  localparam int DEPTH0 = 1024, DEPTH1 = 64, DEPTH2 = 1024;
  localparam int WAIT0  = 0,    WAIT1  = 3,  WAIT2  = 0;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] addr, wdata;
  logic        we;
  logic [3:0]  be;
  logic [2:0]  req;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [int];

  always #5 clk = ~clk;

  SoC_MemBus if0 ();
  SoC_MemBus if1 ();
  SoC_MemBus if2 ();

  assign if0.addr = addr;  assign if0.write_data = wdata;
  assign if0.write_en = we; assign if0.byte_en = be; assign if0.req = req[0];
  assign if1.addr = addr;  assign if1.write_data = wdata;
  assign if1.write_en = we; assign if1.byte_en = be; assign if1.req = req[1];
  assign if2.addr = addr;  assign if2.write_data = wdata;
  assign if2.write_en = we; assign if2.byte_en = be; assign if2.req = req[2];

  soc_mem_responder #(.BASE_ADDRESS(BASE0), .DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(WAIT0))
    u0 (.clk(clk), .res(res), .bus(if0));
  soc_mem_responder #(.BASE_ADDRESS(BASE1), .DEPTH_WORDS(DEPTH1), .WAIT_CYCLES(WAIT1))
    u1 (.clk(clk), .res(res), .bus(if1));
  soc_mem_responder #(.BASE_ADDRESS(BASE2), .DEPTH_WORDS(DEPTH2), .WAIT_CYCLES(WAIT2))
    u2 (.clk(clk), .res(res), .bus(if2));

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : (d == 1) ? BASE1 : BASE2;
  endfunction
  function automatic int depth_of(input int d);
    return (d == 0) ? DEPTH0 : (d == 1) ? DEPTH1 : DEPTH2;
  endfunction
  function automatic int wait_of(input int d);
    return (d == 0) ? WAIT0 : (d == 1) ? WAIT1 : WAIT2;
  endfunction

  function automatic logic obs_valid(input int d);
    return (d == 0) ? if0.valid : (d == 1) ? if1.valid : if2.valid;
  endfunction
  function automatic logic [31:0] obs_rd(input int d);
    return (d == 0) ? if0.read_data : (d == 1) ? if1.read_data : if2.read_data;
  endfunction

  // Reference: a sparse word store per configuration; returns the expected
  // response data and applies any write.
  function automatic logic [31:0] model_access(input int d, input logic [31:0] a,
                                               input logic [31:0] wd, input logic w,
                                               input logic [3:0] lanes);
    logic [31:0] base, word;
    int key;
    base = base_of(d);
    if (a < base || ((a - base) / 4) >= 32'(depth_of(d))) return 32'h0;
    key = d * 4096 + int'((a - base) / 4);
    word = model_mem.exists(key) ? model_mem[key] : 32'h0;
    if (!w) return word;
    for (int n = 0; n < 4; n++)
      if (lanes[n]) word[8*n +: 8] = wd[8*n +: 8];
    model_mem[key] = word;
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on configuration d; checks valid and read_data every
  // cycle up to one past the expected response cycle.
  task automatic run_txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic w, input logic [3:0] lanes, input bit scramble,
                         output logic [31:0] rd_obs);
    logic [31:0] exp_rd;
    int lat;
    exp_rd = model_access(d, a, wd, w, lanes);
    lat = wait_of(d) + 1;
    rd_obs = 32'h0;
    @(negedge clk);
    addr = a; wdata = wd; we = w; be = lanes; req[d] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      check($sformatf("u%0d a=%h cyc%0d valid", d, a, n), 32'(obs_valid(d)), 32'(n == lat));
      check($sformatf("u%0d a=%h cyc%0d rdata", d, a, n), obs_rd(d), (n == lat) ? exp_rd : 32'h0);
      if (n == lat) rd_obs = obs_rd(d);
      if (scramble && n < lat) begin
        addr = $urandom; wdata = $urandom; we = 1'($urandom);
        be = 4'($urandom); req[d] = 1'($urandom);
      end else begin
        req[d] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, a;
    int i;
    res = 1'b0; addr = '0; wdata = '0; we = 1'b0; be = '0; req = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset u%0d valid", d), 32'(obs_valid(d)), 32'h0);
      check($sformatf("reset u%0d rdata", d), obs_rd(d), 32'h0);
    end
    @(posedge clk); #1 res = 1'b1;

    // Full-word write then read, no wait states; first edge after release.
    run_txn(0, 32'h10, 32'hDEADBEEF, 1'b1, 4'b1111, 1'b0, rd);
    run_txn(0, 32'h10, 32'h0, 1'b0, 4'b1111, 1'b0, rd);
    check("word readback", rd, 32'hDEADBEEF);

    // Single-lane write, empty byte_en, ignored low address bits.
    run_txn(0, 32'h10, 32'h00001200, 1'b1, 4'b0010, 1'b0, rd);
    run_txn(0, 32'h10, 32'h0, 1'b0, 4'b0000, 1'b0, rd);
    check("byte lane 1 merge", rd, 32'hDEAD12EF);
    run_txn(0, 32'h10, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0, rd);
    run_txn(0, 32'h13, 32'h0, 1'b0, 4'b0000, 1'b0, rd);
    check("no-lane write + addr[1:0]", rd, 32'hDEAD12EF);

    // Wait states with inputs churning during WAIT.
    run_txn(1, 32'h30, 32'h5A5AA5A5, 1'b1, 4'b1111, 1'b1, rd);
    run_txn(1, 32'h30, 32'h0, 1'b0, 4'b1111, 1'b1, rd);
    check("wait-state readback", rd, 32'h5A5AA5A5);
    run_txn(1, 32'h100, 32'h0, 1'b0, 4'b1111, 1'b0, rd);
    check("depth boundary read", rd, 32'h0);

    // Non-zero base window and its edges.
    run_txn(2, 32'h1000, 32'hCAFEF00D, 1'b1, 4'b1111, 1'b0, rd);
    run_txn(2, 32'h1FFC, 32'h13579BDF, 1'b1, 4'b1111, 1'b0, rd);
    run_txn(2, 32'h2000, 32'h89ABCDEF, 1'b1, 4'b1111, 1'b0, rd);
    run_txn(2, 32'h0FFC, 32'h89ABCDEF, 1'b1, 4'b1111, 1'b0, rd);
    run_txn(2, 32'h2000, 32'h0, 1'b0, 4'b1111, 1'b0, rd);
    check("above window read", rd, 32'h0);
    run_txn(2, 32'h1000, 32'h0, 1'b0, 4'b1111, 1'b0, rd);
    check("window word 0 intact", rd, 32'hCAFEF00D);
    run_txn(2, 32'h1FFC, 32'h0, 1'b0, 4'b1111, 1'b0, rd);
    check("window last word", rd, 32'h13579BDF);

    // Back-to-back: req held across RESP with a new request on the bus.
    @(negedge clk);
    addr = 32'h40; wdata = 32'h0BADF00D; we = 1'b1; be = 4'hF; req[0] = 1'b1;
    void'(model_access(0, 32'h40, 32'h0BADF00D, 1'b1, 4'hF));
    @(posedge clk);
    @(negedge clk);
    check("b2b first valid", 32'(if0.valid), 32'h1);
    check("b2b first rdata", if0.read_data, 32'h0);
    we = 1'b0;
    @(negedge clk);
    check("b2b gap valid", 32'(if0.valid), 32'h0);
    @(negedge clk);
    check("b2b second valid", 32'(if0.valid), 32'h1);
    check("b2b second rdata", if0.read_data, 32'h0BADF00D);
    req[0] = 1'b0;
    @(negedge clk);
    check("b2b after valid", 32'(if0.valid), 32'h0);

    // Reset during WAIT aborts the pending write.
    run_txn(1, 32'h20, 32'h11111111, 1'b1, 4'b1111, 1'b0, rd);
    @(negedge clk);
    addr = 32'h20; wdata = 32'h22222222; we = 1'b1; be = 4'hF; req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    res = 1'b0;
    #1;
    check("abort valid in reset", 32'(if1.valid), 32'h0);
    check("abort rdata in reset", if1.read_data, 32'h0);
    repeat (2) @(negedge clk);
    res = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check($sformatf("abort no valid cyc%0d", n), 32'(if1.valid), 32'h0);
    end
    run_txn(1, 32'h20, 32'h0, 1'b0, 4'b1111, 1'b0, rd);
    check("abort old value kept", rd, 32'h11111111);
    run_txn(0, 32'h10, 32'h0, 1'b0, 4'b1111, 1'b0, rd);
    check("ram survives reset", rd, 32'hDEAD12EF);

    // Randomized traffic per configuration against the model.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 8; k++)
        run_txn(d, base_of(d) + 32'(4 * k), $urandom, 1'b1, 4'hF, 1'b0, rd);
      for (int k = 0; k < 25; k++) begin
        i = $urandom_range(0, 9);
        if (i == 8)      a = base_of(d) - 32'd4;
        else if (i == 9) a = base_of(d) + 32'(4 * depth_of(d)) + 32'(4 * $urandom_range(0, 3));
        else             a = base_of(d) + 32'(4 * i) + 32'($urandom_range(0, 3));
        run_txn(d, a, $urandom, 1'($urandom), 4'($urandom), 1'b1, rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_mem_responder.md
SOC_MEM_RESPONDER -- requirements
Module: soc_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h0000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, RAM size in 32-bit words (power of two, at least 2).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, extra cycles inserted before each response (0..15).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port res  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port bus  SoC_MemBus.Slave  --  responder end of the SoC memory bus: addr[31:0], write_data[31:0], write_en, byte_en[3:0], req in; read_data[31:0], valid out.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-008 In IDLE with req=1 at an edge, SHALL latch addr, write_data, write_en and byte_en, then go to RESP if WAIT_CYCLES=0, else to WAIT with counter loaded to WAIT_CYCLES-1.
REQ-009 In WAIT, SHALL decrement the counter each edge and go to RESP on the edge where the counter is 0.
REQ-010 SHALL perform the RAM access on the edge entering RESP, using latched values only.
REQ-011 SHALL assert valid exactly while in RESP, for one cycle, so that valid is high in cycle k+1+WAIT_CYCLES for a request sampled at edge k.
REQ-012 RESP SHALL always return to IDLE; a req high in the cycle after RESP SHALL be treated as a new transaction.
REQ-013 Word index SHALL be (addr-BASE_ADDRESS)>>2, with addr[1:0] ignored.
REQ-014 A write SHALL update only the byte lanes with byte_en[n]=1 (lane n = bits 8n+7:8n); byte_en=0000 SHALL leave memory unchanged but still respond.
REQ-015 In RESP, read_data SHALL be the full addressed word for a read and 32'h0 for a write; outside RESP it SHALL be 32'h0.
REQ-016 For an address below BASE_ADDRESS or at/above BASE_ADDRESS+4*DEPTH_WORDS, a write SHALL be dropped and a read SHALL return 32'h0, with valid still asserted per REQ-011.
REQ-017 If req deasserts in WAIT, SHALL still complete the access and pulse valid, with no abort.
REQ-018 Changes on bus inputs after latching SHALL not affect the transaction in flight.
REQ-019 SHALL support only one outstanding transaction; req is ignored outside IDLE.

Reset
REQ-020 While res=0, SHALL hold state=IDLE, counter=0, valid=0, read_data=32'h0, and latched request registers at 0.
REQ-021 Reset asserted in WAIT or RESP SHALL abort the transaction immediately, with no pending write committed and no valid pulse after release.
REQ-022 RAM contents SHALL NOT be cleared by reset.
REQ-023 First request SHALL be accepted at the first rising edge with res=1.

Structure
REQ-024 Shared package soc_pkg SHALL hold the FSM state enum, the bus data/address width constants (32) and the byte-lane count (4).
REQ-025 RAM SHALL be a separate sub-module soc_spram: single port, synchronous read, per-byte write enable, DEPTH_WORDS x 32.
REQ-026 The counter width SHALL be 4 bits; the RAM index width SHALL be $clog2(DEPTH_WORDS).

Verification
REQ-027 WAIT_CYCLES=0, BASE=0: write 32'hDEADBEEF to 0x10 with byte_en=1111, then read 0x10 -> valid one cycle after each req edge; read_data=DEADBEEF in the read RESP cycle and 0 in the write RESP cycle.
REQ-028 Preload 0x10=DEADBEEF; write 32'h00001200 with byte_en=0010; read -> DEAD12EF.
REQ-029 WAIT_CYCLES=3: read sampled at edge k -> valid high only in cycle k+4; inputs changed during WAIT do not alter the result.
REQ-030 BASE=0x1000, DEPTH=1024: write to 0x2000, then read 0x2000 -> both get a valid pulse, read_data=0, and memory word 0 is unchanged.
REQ-031 WAIT_CYCLES=3: assert res=0 during WAIT of a write to 0x20 (old value 0x11111111) -> valid stays 0, state returns to IDLE, and reading 0x20 after release returns 0x11111111.
REQ-032 Back-to-back: hold req high across RESP with a new addr -> the second transaction starts in IDLE the next cycle, giving exactly two valid pulses separated by one idle cycle (WAIT_CYCLES=0).
